// File: rtl/sec_inicio_rtc_if.sv
// Write-side bus between the RTC init sequencer and the bus writer:
// one address/data pair qualified by a req/ack handshake.
interface sec_inicio_rtc_if #(
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic              wr_ack;
    logic [DATA_W-1:0] dir;
    logic [DATA_W-1:0] dat;

    modport master (output wr_req, dir, dat, input wr_ack);
    modport slave  (input wr_req, dir, dat, output wr_ack);
endinterface

// File: rtl/sec_inicio_rtc.sv
// RTC start-up sequencer: walks a table of address/data pairs, issuing each
// as a req/ack write with a gap cycle between writes, a timeout and an abort.
module sec_inicio_rtc #(
    parameter int                          DATA_W    = 8,
    parameter int                          N_PASOS   = 4,
    parameter logic [N_PASOS*DATA_W-1:0]   TABLA_DIR = {8'h10, 8'h10, 8'h02, 8'h02},
    parameter logic [N_PASOS*DATA_W-1:0]   TABLA_DAT = {8'h00, 8'hD2, 8'h00, 8'h10},
    parameter int                          TIMEOUT   = 255,
    localparam int                         CW        = (N_PASOS > 1) ? $clog2(N_PASOS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic                    i_start,
    sec_inicio_rtc_if.master        bus,
    output logic [CW-1:0]           o_cuenta,
    output logic                    o_ocupado,
    output logic                    o_fin,
    output logic                    o_error
);
    localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   ULTIMO = CW'(N_PASOS - 1);
    localparam logic [TW-1:0]   T_LIM  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EMITIR = 3'd1,
        S_PAUSA  = 3'd2,
        S_FIN    = 3'd3,
        S_ERROR  = 3'd4
    } estado_t;

    estado_t            r_estado;
    estado_t            w_estado;
    logic               r_wr_req, w_wr_req;
    logic [DATA_W-1:0]  r_dir, w_dir;
    logic [DATA_W-1:0]  r_dat, w_dat;
    logic [CW-1:0]      r_cuenta, w_cuenta;
    logic               r_ocupado, w_ocupado;
    logic               r_fin, w_fin;
    logic               r_error, w_error;
    logic [TW-1:0]      r_timer, w_timer;
    logic               w_expira;
    logic               w_ultimo;

    function automatic logic [DATA_W-1:0] fila(input logic [N_PASOS*DATA_W-1:0] tabla,
                                               input logic [CW-1:0] idx);
        return tabla[int'(idx)*DATA_W +: DATA_W];
    endfunction

    assign w_expira = (TIMEOUT != 0) && (r_timer == T_LIM);
    assign w_ultimo = (r_cuenta == ULTIMO);

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_estado  <= S_IDLE;
            r_wr_req  <= 1'b0;
            r_dir     <= '0;
            r_dat     <= '0;
            r_cuenta  <= '0;
            r_ocupado <= 1'b0;
            r_fin     <= 1'b0;
            r_error   <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_estado  <= w_estado;
            r_wr_req  <= w_wr_req;
            r_dir     <= w_dir;
            r_dat     <= w_dat;
            r_cuenta  <= w_cuenta;
            r_ocupado <= w_ocupado;
            r_fin     <= w_fin;
            r_error   <= w_error;
            r_timer   <= w_timer;
        end
    end

    // Next-state logic; dropping enable overrides everything
    always_comb begin
        w_estado = r_estado;
        if (!i_en) begin
            w_estado = S_IDLE;
        end else begin
            case (r_estado)
                S_IDLE, S_ERROR: begin
                    if (i_start) begin
                        w_estado = S_EMITIR;
                    end else begin
                        w_estado = r_estado;
                    end
                end
                S_EMITIR: begin
                    if (bus.wr_ack) begin
                        w_estado = w_ultimo ? S_FIN : S_PAUSA;
                    end else if (w_expira) begin
                        w_estado = S_ERROR;
                    end else begin
                        w_estado = S_EMITIR;
                    end
                end
                S_PAUSA: w_estado = S_EMITIR;
                S_FIN:   w_estado = S_IDLE;
                default: w_estado = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; an ack in the expiry cycle wins
    always_comb begin
        w_wr_req  = r_wr_req;
        w_dir     = r_dir;
        w_dat     = r_dat;
        w_cuenta  = r_cuenta;
        w_ocupado = r_ocupado;
        w_fin     = 1'b0;
        w_error   = r_error;
        w_timer   = r_timer;
        if (!i_en) begin
            w_wr_req  = 1'b0;
            w_dir     = '0;
            w_dat     = '0;
            w_ocupado = 1'b0;
        end else begin
            case (r_estado)
                S_IDLE, S_ERROR: begin
                    if (i_start) begin
                        w_cuenta  = '0;
                        w_dir     = fila(TABLA_DIR, '0);
                        w_dat     = fila(TABLA_DAT, '0);
                        w_wr_req  = 1'b1;
                        w_ocupado = 1'b1;
                        w_timer   = '0;
                        w_error   = (r_estado == S_ERROR) ? 1'b0 : r_error;
                    end else begin
                        w_wr_req  = 1'b0;
                    end
                end
                S_EMITIR: begin
                    w_timer = r_timer + TW'(1);
                    if (bus.wr_ack) begin
                        w_wr_req = 1'b0;
                        w_dir    = '0;
                        w_dat    = '0;
                        if (w_ultimo) begin
                            w_fin = 1'b1;
                        end else begin
                            w_cuenta = r_cuenta + CW'(1);
                        end
                    end else if (w_expira) begin
                        w_wr_req  = 1'b0;
                        w_dir     = '0;
                        w_dat     = '0;
                        w_error   = 1'b1;
                        w_ocupado = 1'b0;
                    end else begin
                        w_wr_req  = 1'b1;
                    end
                end
                S_PAUSA: begin
                    w_dir    = fila(TABLA_DIR, r_cuenta);
                    w_dat    = fila(TABLA_DAT, r_cuenta);
                    w_wr_req = 1'b1;
                    w_timer  = '0;
                end
                S_FIN: begin
                    w_ocupado = 1'b0;
                end
                default: begin
                    w_wr_req  = 1'b0;
                    w_ocupado = 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_req = r_wr_req;
    assign bus.dir    = r_dir;
    assign bus.dat    = r_dat;
    assign o_cuenta   = r_cuenta;
    assign o_ocupado  = r_ocupado;
    assign o_fin      = r_fin;
    assign o_error    = r_error;
endmodule

// File: tb/tb_sec_inicio_rtc.sv
// Scoreboard bench: stimulus pushes expected write/fin/error events derived from
// the init table and the planned ack delays; a monitor pops them as the DUTs act.
module tb_sec_inicio_rtc;
    localparam int TO_A = 6;
    localparam int K_WR = 0, K_FIN = 1, K_ERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] dir;
        logic [7:0] dat;
        int         cnt;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en [2];
    logic       start [2];
    logic       ack [2];
    logic       noise;
    logic       req [2];
    logic [7:0] dir_v [2];
    logic [7:0] dat_v [2];
    logic [3:0] cnt_v [2];
    logic       ocup [2];
    logic       fin_o [2];
    logic       err [2];
    logic [1:0] cuenta_a;
    logic [0:0] cuenta_b;

    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q [2][$];
    int  dly_q [2][$];
    int  dl [4];

    logic [7:0] m_dir [4] = '{8'h02, 8'h02, 8'h10, 8'h10};
    logic [7:0] m_dat [4] = '{8'h10, 8'h00, 8'hD2, 8'h00};

    sec_inicio_rtc_if #(.DATA_W(8)) bus_a ();
    sec_inicio_rtc_if #(.DATA_W(8)) bus_b ();

    sec_inicio_rtc #(.DATA_W(8), .N_PASOS(4), .TIMEOUT(TO_A)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_en(en[0]), .i_start(start[0]), .bus(bus_a.master),
        .o_cuenta(cuenta_a), .o_ocupado(ocup[0]), .o_fin(fin_o[0]), .o_error(err[0])
    );

    sec_inicio_rtc #(.DATA_W(8), .N_PASOS(1), .TABLA_DIR(8'h02), .TABLA_DAT(8'h10),
                     .TIMEOUT(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_en(en[1]), .i_start(start[1]), .bus(bus_b.master),
        .o_cuenta(cuenta_b), .o_ocupado(ocup[1]), .o_fin(fin_o[1]), .o_error(err[1])
    );

    assign req[0] = bus_a.wr_req;
    assign req[1] = bus_b.wr_req;
    assign dir_v[0] = bus_a.dir;
    assign dir_v[1] = bus_b.dir;
    assign dat_v[0] = bus_a.dat;
    assign dat_v[1] = bus_b.dat;
    assign bus_a.wr_ack = ack[0];
    assign bus_b.wr_ack = ack[1];
    assign cnt_v[0] = {2'b00, cuenta_a};
    assign cnt_v[1] = {3'b000, cuenta_b};

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, got, exp);
        end
    endtask

    function automatic int to_of(input int d);
        return (d == 0) ? TO_A : 1000000;
    endfunction

    function automatic ev_t mk(input int k, input logic [7:0] a, input logic [7:0] b, input int c);
        ev_t e;
        e.kind = k; e.dir = a; e.dat = b; e.cnt = c;
        return e;
    endfunction

    // Expected events: each step is written unless its ack comes too late.
    task automatic set_plan(input int d, input int n);
        dly_q[d].delete();
        for (int s = 0; s < n; s++) dly_q[d].push_back(dl[s]);
        for (int s = 0; s < n; s++) begin
            if (dl[s] >= to_of(d)) begin
                exp_q[d].push_back(mk(K_ERR, 8'h00, 8'h00, s));
                return;
            end
            exp_q[d].push_back(mk(K_WR, m_dir[s], m_dat[s], s));
        end
        exp_q[d].push_back(mk(K_FIN, 8'h00, 8'h00, n - 1));
    endtask

    task automatic observe(input int d, input ev_t g);
        ev_t e;
        if (exp_q[d].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event dut%0d: got kind %0d dir %0h dat %0h cnt %0d, expected none",
                     d, g.kind, g.dir, g.dat, g.cnt);
        end else begin
            e = exp_q[d].pop_front();
            chk("event_kind", d, g.kind, e.kind);
            chk("event_dir", d, {24'd0, g.dir}, {24'd0, e.dir});
            chk("event_dat", d, {24'd0, g.dat}, {24'd0, e.dat});
            chk("event_cuenta", d, g.cnt, e.cnt);
        end
    endtask

    task automatic pulse(input int d);
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget, input bit poke);
        int k = 0;
        while (k < budget) begin
            @(negedge clk);
            start[d] = poke && ocup[d] && ($urandom_range(0, 3) == 0);
            #3;
            if (exp_q[d].size() == 0 && !ocup[d] && !start[d]) break;
            k++;
        end
        start[d] = 1'b0;
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle dut%0d: %0d events still pending after %0d cycles, expected 0",
                     d, exp_q[d].size(), budget);
            exp_q[d].delete();
        end
    endtask

    task automatic wait_step(input int d, input int step);
        int k = 0;
        while (k < 60) begin
            @(negedge clk);
            #3;
            if (req[d] && cnt_v[d] == 4'(step)) break;
            k++;
        end
        chk("wait_step_reached", d, k < 60, 1);
    endtask

    task automatic chk_zero(input string nm, input int d);
        chk({nm, "_req"}, d, req[d], 0);
        chk({nm, "_dir"}, d, dir_v[d], 0);
        chk({nm, "_dat"}, d, dat_v[d], 0);
        chk({nm, "_ocupado"}, d, ocup[d], 0);
        chk({nm, "_fin"}, d, fin_o[d], 0);
    endtask

    // Bus writer model: acks a request after its planned number of wait cycles.
    initial begin
        int   cur [2];
        int   cnt [2];
        logic prev [2];
        for (int d = 0; d < 2; d++) begin
            ack[d] = 1'b0; prev[d] = 1'b0; cur[d] = 0; cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (req[d]) begin
                    if (!prev[d]) begin
                        cur[d] = (dly_q[d].size() > 0) ? dly_q[d].pop_front() : 1000000;
                        cnt[d] = 0;
                    end
                    ack[d] = (cnt[d] == cur[d]);
                    cnt[d]++;
                end else begin
                    ack[d] = noise && ($urandom_range(0, 1) == 1);
                end
                prev[d] = req[d];
            end
        end
    end

    // Monitor: handshakes, fin and error edges feed the scoreboard; bus rules checked inline.
    initial begin
        int         cyc [2];
        int         last_hs [2];
        logic       p_req [2];
        logic       p_hs [2];
        logic       p_err [2];
        logic [7:0] p_dir [2];
        logic [7:0] p_dat [2];
        logic       hs;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; last_hs[d] = -10; p_req[d] = 1'b0; p_hs[d] = 1'b0;
            p_err[d] = 1'b0; p_dir[d] = 8'h00; p_dat[d] = 8'h00;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                cyc[d]++;
                hs = req[d] && ack[d] && en[d] && !rst;
                if (req[d] && p_req[d] && !p_hs[d]) begin
                    chk("dir_stable", d, dir_v[d], p_dir[d]);
                    chk("dat_stable", d, dat_v[d], p_dat[d]);
                end
                if (p_hs[d]) chk("req_gap_after_ack", d, req[d], 0);
                if (hs) observe(d, mk(K_WR, dir_v[d], dat_v[d], int'(cnt_v[d])));
                if (fin_o[d]) begin
                    chk("fin_after_last_ack", d, cyc[d] - last_hs[d], 1);
                    observe(d, mk(K_FIN, 8'h00, 8'h00, int'(cnt_v[d])));
                end
                if (err[d] && !p_err[d]) begin
                    chk("err_req_low", d, req[d], 0);
                    chk("err_ocupado_low", d, ocup[d], 0);
                    observe(d, mk(K_ERR, 8'h00, 8'h00, int'(cnt_v[d])));
                end
                if (hs) last_hs[d] = cyc[d];
                p_req[d] = req[d]; p_hs[d] = hs; p_err[d] = err[d];
                p_dir[d] = dir_v[d]; p_dat[d] = dat_v[d];
            end
        end
    end

    initial begin
        rst = 1'b1; noise = 1'b0;
        for (int d = 0; d < 2; d++) begin en[d] = 1'b0; start[d] = 1'b0; end
        repeat (3) @(negedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            chk_zero("reset", d);
            chk("reset_cuenta", d, cnt_v[d], 0);
            chk("reset_error", d, err[d], 0);
        end
        @(negedge clk);
        rst = 1'b0; en[0] = 1'b1; en[1] = 1'b1;

        // Immediate acks: exact cycle-by-cycle timing after the start edge
        dl = '{0, 0, 0, 0};
        set_plan(0, 4);
        @(negedge clk);
        start[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            #3;
            chk("lat_req", c, req[0], (c % 2 == 1) && (c <= 7));
            chk("lat_fin", c, fin_o[0], c == 8);
            chk("lat_ocupado", c, ocup[0], c <= 8);
        end
        wait_idle(0, 20, 1'b0);

        // Ack on step 2 arrives in the last cycle before expiry: ack wins
        dl = '{0, 0, 5, 0};
        set_plan(0, 4);
        pulse(0);
        wait_idle(0, 100, 1'b0);

        // No ack on step 1: timeout, then a new start clears error and replays
        dl = '{0, TO_A, 0, 0};
        set_plan(0, 4);
        pulse(0);
        wait_idle(0, 100, 1'b0);
        chk("timeout_error", 0, err[0], 1);
        chk("timeout_cuenta", 0, cnt_v[0], 1);
        chk_zero("timeout", 0);
        dl = '{0, 0, 0, 0};
        set_plan(0, 4);
        pulse(0);
        #3;
        chk("restart_error_cleared", 0, err[0], 0);
        wait_idle(0, 100, 1'b0);

        // Enable dropped during step 2
        dly_q[0].delete();
        dly_q[0].push_back(0); dly_q[0].push_back(0); dly_q[0].push_back(TO_A);
        exp_q[0].push_back(mk(K_WR, m_dir[0], m_dat[0], 0));
        exp_q[0].push_back(mk(K_WR, m_dir[1], m_dat[1], 1));
        pulse(0);
        wait_step(0, 2);
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        #3;
        chk_zero("abort", 0);
        chk("abort_error", 0, err[0], 0);
        en[0] = 1'b1;
        dly_q[0].delete();
        wait_idle(0, 20, 1'b0);
        dl = '{0, 0, 0, 0};
        set_plan(0, 4);
        pulse(0);
        wait_idle(0, 100, 1'b0);

        // Reset in the middle of step 1
        dly_q[0].delete();
        dly_q[0].push_back(0); dly_q[0].push_back(TO_A);
        exp_q[0].push_back(mk(K_WR, m_dir[0], m_dat[0], 0));
        pulse(0);
        wait_step(0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk_zero("midreset", 0);
        chk("midreset_cuenta", 0, cnt_v[0], 0);
        chk("midreset_error", 0, err[0], 0);
        rst = 1'b0;
        dly_q[0].delete();
        wait_idle(0, 20, 1'b0);

        // Single-step table, no timeout, very late ack
        dl = '{300, 0, 0, 0};
        set_plan(1, 1);
        pulse(1);
        wait_idle(1, 500, 1'b0);
        chk("late_ack_no_error", 1, err[1], 0);

        // Random ack delays with spurious acks and re-pulsed starts
        noise = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int s = 0; s < 4; s++) dl[s] = $urandom_range(0, TO_A + 1);
            set_plan(0, 4);
            pulse(0);
            wait_idle(0, 200, 1'b1);
        end
        noise = 1'b0;

        repeat (3) @(negedge clk);
        chk("leftover_events_a", 0, exp_q[0].size(), 0);
        chk("leftover_events_b", 1, exp_q[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sec_inicio_rtc.md
Name: sec_inicio_rtc

Overview:
- Parametrised initialisation sequencer for the RTC write path.
- After a start pulse, steps through a table of N_PASOS address/data pairs and presents each pair to the bus writer with a req/ack handshake.
- Signals completion, or a timeout error if the writer does not acknowledge.
- Replaces the fixed 4-entry combinational start-up table; adds timing, handshake, abort and error reporting.

Parameters:
- DATA_W, 8, width of address and data words.
- N_PASOS, 4, number of init writes (1..16).
- TABLA_DIR, {8'h10,8'h10,8'h02,8'h02}, packed N_PASOS*DATA_W addresses; step 0 in the LSBs.
- TABLA_DAT, {8'h00,8'hD2,8'h00,8'h10}, packed N_PASOS*DATA_W data; step 0 in the LSBs.
- TIMEOUT, 255, maximum EMITIR cycles to wait for ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  block enable; low aborts any sequence.
- start  in  1  start request, sampled in IDLE/ERROR.
- wr_ack  in  1  bus writer has accepted the current pair.
- wr_req  out  1  pair on dir/dat is valid; write requested.
- dir  out  DATA_W  RTC register address.
- dat  out  DATA_W  data for that address.
- cuenta  out  clog2(N_PASOS) (min 1)  current step index.
- ocupado  out  1  sequence in progress.
- fin  out  1  one-cycle pulse when the last write is acknowledged.
- error  out  1  sticky timeout flag.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- All outputs are registered. On reset: state=IDLE, wr_req=0, dir=0, dat=0, cuenta=0, ocupado=0, fin=0, error=0, timer=0.
- States: IDLE, EMITIR, PAUSA, FIN, ERROR.
- IDLE: if en & start, then cuenta<=0, dir/dat<=table[0], wr_req<=1, ocupado<=1, timer<=0, go to EMITIR. Otherwise hold.
- EMITIR: wr_req=1 and dir/dat are held stable; timer increments each cycle.
  - If wr_ack=1 and cuenta==N_PASOS-1: wr_req<=0, dir/dat<=0, go to FIN.
  - If wr_ack=1 and cuenta<N_PASOS-1: wr_req<=0, dir/dat<=0, cuenta<=cuenta+1, go to PAUSA.
  - If no ack, TIMEOUT!=0 and timer==TIMEOUT-1: wr_req<=0, dir/dat<=0, error<=1, ocupado<=0, go to ERROR.
  - If wr_ack and timeout expiry occur in the same cycle, ack wins.
- PAUSA: exactly one cycle with wr_req=0. Then dir/dat<=table[cuenta], wr_req<=1, timer<=0, go to EMITIR. This guarantees wr_req drops between consecutive writes.
- FIN: fin=1 for exactly one cycle, ocupado<=0, go to IDLE. cuenta keeps N_PASOS-1 until the next start.
- ERROR: error stays 1 and cuenta holds the failing step. On en & start, clear error and begin at step 0 exactly as from IDLE.
- wr_ack is ignored outside EMITIR.
- start while ocupado=1 is ignored.
- en=0 in any state: next edge forces IDLE, wr_req=0, dir/dat=0, ocupado=0, no fin. error is left unchanged.
- reset mid-sequence returns every output to its reset value on that edge.
- Latency: with ack in the first EMITIR cycle of every step, wr_req first rises on the edge after start. fin rises 2*N_PASOS edges after the start edge, i.e. 8 cycles for N_PASOS=4.

Test Plan:
- Defaults, start pulse, wr_ack immediate on every request: pairs (02,10), (02,00), (10,D2), (10,00) each held one cycle; wr_req low one cycle between pairs; fin pulses 8 cycles after start; ocupado is high across cycles 1..8.
- Ack delayed 5 cycles on step 2: dir=10 and dat=D2 stay stable for 6 cycles; no error; fin still arrives; cuenta reads 0,1,2,3 across the run.
- TIMEOUT=4, no ack on step 1: wr_req drops after 4 EMITIR cycles; error=1, cuenta=1, ocupado=0, no fin. A new start clears error and replays from (02,10).
- en pulled low during step 2 EMITIR: next edge wr_req=0, dir=dat=0, ocupado=0, no fin. A new start restarts at step 0.
- start re-pulsed mid-sequence and wr_ack asserted while in IDLE/PAUSA: no effect on sequence or outputs. reset asserted mid-step 1: all outputs are 0 on the following edge.
- N_PASOS=1, TIMEOUT=0, ack after 300 cycles: no error; single pair (02,10) is emitted; fin follows on the edge after ack is sampled.
